mem_lsu: RTL
============

# mem_lsu

Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It takes the load or store held in the EX/MEM pipeline register and issues it as a single command on the MEM_CMD start/busy/done port. It stalls the pipeline until the command completes, then returns byte-lane-aligned, sign- or zero-extended load data and the RVFI masks to the MEM/WB register. Misaligned accesses never reach the bus; they are reported as traps.

## Interface
Parameters:
- ADDR_WIDTH, 32, command address width.
- DATA_WIDTH, 32, data width; only 32 is supported, enforced by an elaboration check.

Ports:
- clk_i  in  1  sole clock; all state on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- mem_valid_i  in  1  MEM stage holds a valid instruction.
- mem_load_i / mem_store_i  in  1 each  instruction is a load / store; never both.
- mem_funct3_i  in  3  RV32I width and sign: LB/LH/LW/LBU/LHU, SB/SH/SW.
- mem_addr_i  in  32  effective byte address (ALU result).
- mem_wdata_i  in  32  rs2 store data.
- mem_kill_i  in  1  trap flush of the MEM stage.
- cmd_start_o  out  1  one-cycle command strobe.
- cmd_we_o  out  1  1 = write.
- cmd_addr_o  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}.
- cmd_wdata_o  out  32  lane-replicated store data.
- cmd_sel_o  out  4  byte enables.
- cmd_rdata_i  in  32  read data; valid while cmd_done_i.
- cmd_busy_i  in  1  slave cannot accept a start.
- cmd_done_i  in  1  one-cycle completion pulse.
- lsu_stall_o  out  1  to hazard unit; stall IF..EX/MEM and bubble MEM/WB.
- load_rdata_o  out  32  extended load result.
- load_rmask_o / store_wmask_o  out  4 each  RVFI masks.
- store_wdata_o  out  32  RVFI store data, equal to cmd_wdata_o.
- misaligned_load_o / misaligned_store_o  out  1 each  trap requests; cause 4 / 6.

## Operation
- The access is aligned when:
  - byte accesses: always;
  - half accesses: addr[0]==0;
  - word accesses: addr[1:0]==0.
- A misaligned access raises the matching misaligned_* output combinationally in the same cycle. No command is issued, there is no stall, and the masks are 0.
- Stores:
  - SB: sel=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: sel=0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: sel=1111, wdata=rs2.
- Loads: the same sel pattern is used. Data is taken from the addressed lane, then sign-extended (LB, LH) or zero-extended (LBU, LHU). LW passes through.
- FSM states:
  - IDLE: a valid, aligned, unkilled request with !cmd_busy_i pulses cmd_start_o and moves to WAIT. If cmd_busy_i is high, stay in IDLE with the stall asserted. cmd_done_i is ignored in IDLE.
  - WAIT: on cmd_done_i, register the extended load data and go to RESP.
  - RESP: lsu_stall_o=0 and load_rdata_o is valid for one cycle, so the pipeline advances. Next state is IDLE.
- lsu_stall_o = (IDLE & request & !misaligned & !kill) | WAIT.
- cmd_* outputs are held stable from start until done.
- Kill in IDLE: no command is issued.
- Kill in WAIT: the command is already issued and must complete. Stay in WAIT with the stall held until done. On done, discard the data (load_rdata_o stays 0, no RESP pulse) and return to IDLE.
- Reset in any state: return to IDLE. The in-flight command is abandoned; the slave is reset on the same rst_i.

## Timing
- Reset values: all outputs 0, state IDLE.
- Minimum load/store occupancy is 3 cycles:
  - cycle 0: start;
  - cycle 1 at the earliest: done;
  - cycle 2: RESP, stall low.
- The stall is therefore high for 2 cycles minimum.
- load_rdata_o is registered, with 1-cycle latency after done.
- A start is never issued in the same cycle as RESP; back-to-back accesses have their starts at least 3 cycles apart.
- Non-memory instructions: no stall, 0-cycle pass.

## Structure
- The following go in params_pkg:
  - lsu_state_e (IDLE/WAIT/RESP);
  - the funct3 constants (LB..SW);
  - the trap cause constants MISALIGNED_LOAD=4 and MISALIGNED_STORE=6.
- One natural sub-module: lsu_align, purely combinational. It produces sel, wdata and misaligned from funct3 and addr, and performs load extraction/extension.

## Test plan
- SW to 0x100 with rs2=0xDEADBEEF and 1-cycle done → start once; sel=1111; addr=0x100; stall high for 2 cycles; wmask=1111.
- LB at 0x103 with rdata=0x80FFFFFF → sel=1000; load_rdata_o=0xFFFFFF80 in RESP. The same access as LBU gives 0x00000080.
- LH at 0x101 → misaligned_load_o=1 the same cycle; no start; stall 0. SW at 0x102 → misaligned_store_o=1.
- cmd_busy_i held high for 5 cycles with an LW pending → start is delayed exactly until busy drops, stall high throughout, exactly one start.
- mem_kill_i asserted during WAIT, with done 4 cycles later → stall held until done, no RESP, load_rdata_o=0; the next request is issued normally.
- rst_i asserted while in WAIT → next cycle IDLE, all outputs 0, a later done pulse is ignored.

Source files
------------

// File: rtl/params_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | params_pkg : shared types and constants for the MEM-stage LSU    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package params_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [3:0] MISALIGNED_LOAD  = 4'd4;
  localparam logic [3:0] MISALIGNED_STORE = 4'd6;

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lsu_if : single-command start/busy/done memory port          |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mem_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_start;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;
  logic [3:0]            cmd_sel;
  logic [31:0]           cmd_rdata;
  logic                  cmd_busy;
  logic                  cmd_done;

  modport master (
    output cmd_start, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    input  cmd_rdata, cmd_busy, cmd_done
  );

  modport slave (
    input  cmd_start, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    output cmd_rdata, cmd_busy, cmd_done
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_align : byte-lane select, store replication, alignment check |
// | and load extraction/extension (combinational)   rev 1.0          |
// +------------------------------------------------------------------+
module lsu_align
  import params_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [3:0]  sel,
  output logic [31:0] lane_wdata,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store funct3 encodings coincide with the load ones, so one decode serves both.
  always_comb begin
    sel        = 4'b0000;
    lane_wdata = 32'h0;
    misaligned = 1'b0;
    case (funct3)
      LB, LBU: begin
        sel        = 4'b0001 << addr_lo;
        lane_wdata = {4{rs2[7:0]}};
      end
      LH, LHU: begin
        sel        = 4'b0011 << addr_lo;
        lane_wdata = {2{rs2[15:0]}};
        misaligned = addr_lo[0];
      end
      LW: begin
        sel        = 4'b1111;
        lane_wdata = rs2;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = rdata;
    ld_byte = rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LBU:     ld_data = {24'h0, ld_byte};
      LHU:     ld_data = {16'h0, ld_half};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lsu : MEM-stage load/store unit, one bus command per access  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_lsu
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_valid_i,
  input  logic              mem_load_i,
  input  logic              mem_store_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic              mem_kill_i,
  mem_lsu_if.master         cmd,
  output logic              lsu_stall_o,
  output logic [31:0]       load_rdata_o,
  output logic [3:0]        load_rmask_o,
  output logic [3:0]        store_wmask_o,
  output logic [31:0]       store_wdata_o,
  output logic              misaligned_load_o,
  output logic              misaligned_store_o
);

  generate
    if (DATA_WIDTH != 32) begin : g_width_check
      $error("mem_lsu supports DATA_WIDTH = 32 only");
    end
  endgenerate

  lsu_state_e            state, state_nx;
  logic                  request, mis, start, stall, capture, discard, killed;
  logic [3:0]            sel, sel_q;
  logic [31:0]           lane_wdata, ld_data, wdata_now, wdata_q, load_q;
  logic [ADDR_WIDTH-1:0] addr_now, addr_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;

  assign request   = mem_valid_i & (mem_load_i | mem_store_i);
  assign addr_now  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign wdata_now = mem_store_i ? lane_wdata : 32'h0;
  assign discard   = killed | mem_kill_i;

  lsu_align u_align (
    .funct3     (mem_funct3_i),
    .addr_lo    (mem_addr_i[1:0]),
    .rs2        (mem_wdata_i),
    .sel        (sel),
    .lane_wdata (lane_wdata),
    .misaligned (mis),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .rdata      (cmd.cmd_rdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    stall    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (request && !mis && !mem_kill_i) begin
          stall = 1'b1;
          if (!cmd.cmd_busy) begin
            start    = 1'b1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cmd.cmd_done) begin
          capture  = !discard;
          state_nx = discard ? IDLE : RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      killed    <= 1'b0;
      load_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
    end else begin
      state  <= state_nx;
      // A kill seen while the command is in flight is remembered until done.
      killed <= (state == WAIT) && !cmd.cmd_done && discard;
      load_q <= capture ? ld_data : 32'h0;
      if (start) begin
        we_q      <= mem_store_i;
        addr_q    <= addr_now;
        wdata_q   <= wdata_now;
        sel_q     <= sel;
        funct3_q  <= mem_funct3_i;
        addr_lo_q <= mem_addr_i[1:0];
      end
    end
  end

  assign cmd.cmd_start = start;
  assign cmd.cmd_we    = start ? mem_store_i : we_q;
  assign cmd.cmd_addr  = start ? addr_now    : addr_q;
  assign cmd.cmd_wdata = start ? wdata_now   : wdata_q;
  assign cmd.cmd_sel   = start ? sel         : sel_q;

  assign lsu_stall_o        = stall;
  assign load_rdata_o       = load_q;
  assign store_wdata_o      = cmd.cmd_wdata;
  assign load_rmask_o       = (request && mem_load_i && !mis && !mem_kill_i) ? sel : 4'b0000;
  assign store_wmask_o      = (request && mem_store_i && !mis && !mem_kill_i) ? sel : 4'b0000;
  assign misaligned_load_o  = request & mem_load_i & mis;
  assign misaligned_store_o = request & mem_store_i & mis;

endmodule
`default_nettype wire
